// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - ID stage: opcode decode, 32x64 register file read, ID/EX pipeline register
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   instruction_ID, pc_ID      instruction and its PC from the IF/ID register
//   flush                      turns the next ID/EX entry into a bubble
//   wb_regwrite/wb_rd/wb_data  write-back port into the register file
//   *_EX                       registered ID/EX outputs (operands, immediate, controls)
module instruction_decode #(
    parameter int          ZERO_REG = 31,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_ID,
    input  logic [63:0] pc_ID,
    input  logic        flush,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_data,
    output logic [63:0] pc_EX,
    output logic [63:0] busA_EX,
    output logic [63:0] busB_EX,
    output logic [63:0] extimm_EX,
    output logic [4:0]  rd_EX,
    output logic [3:0]  alu_ctrl_EX,
    output logic        alusrc_EX,
    output logic        memtoreg_EX,
    output logic        regwrite_EX,
    output logic        memread_EX,
    output logic        memwrite_EX,
    output logic        branch_EX,
    output logic        uncondbranch_EX,
    output logic        invalid_EX
);

    localparam logic [4:0] ZR = 5'(ZERO_REG);

    typedef enum logic [3:0] {
        OP_INV, OP_LDUR, OP_STUR, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_CBZ, OP_B, OP_MOVZ
    } op_t;

    op_t         op;
    logic [63:0] regs [32];
    logic [4:0]  rn;
    logic [4:0]  rb;
    logic [63:0] read_a;
    logic [63:0] read_b;
    logic [63:0] imm;
    logic [3:0]  alu;
    logic        c_alusrc, c_memtoreg, c_regwrite, c_memread, c_memwrite, c_branch, c_uncond;
    logic        wb_en;

    // Opcode classes are disjoint, so the order of the patterns does not matter.
    always_comb begin
        op = OP_INV;
        casez (instruction_ID[31:21])
            11'b11111000010: op = OP_LDUR;
            11'b11111000000: op = OP_STUR;
            11'b10001011000: op = OP_ADD;
            11'b11001011000: op = OP_SUB;
            11'b10001010000: op = OP_AND;
            11'b10101010000: op = OP_ORR;
            11'b10110100???: op = OP_CBZ;
            11'b000101?????: op = OP_B;
            11'b110100101??: op = OP_MOVZ;
            default:         op = OP_INV;
        endcase
    end

    // STUR and CBZ carry their data register in the Rt field, not in Rm.
    assign rn    = instruction_ID[9:5];
    assign rb    = (op == OP_STUR || op == OP_CBZ) ? instruction_ID[4:0] : instruction_ID[20:16];
    assign wb_en = wb_regwrite && (wb_rd != ZR);

    // Write-back bypass so a value retiring this cycle is seen by the instruction being decoded.
    always_comb begin
        read_a = regs[rn];
        read_b = regs[rb];
        if (wb_en && wb_rd == rn) read_a = wb_data;
        if (wb_en && wb_rd == rb) read_b = wb_data;
        if (rn == ZR) read_a = '0;
        if (rb == ZR) read_b = '0;
    end

    always_comb begin
        imm        = '0;
        alu        = 4'b0000;
        c_alusrc   = 1'b0;
        c_memtoreg = 1'b0;
        c_regwrite = 1'b0;
        c_memread  = 1'b0;
        c_memwrite = 1'b0;
        c_branch   = 1'b0;
        c_uncond   = 1'b0;
        unique case (op)
            OP_LDUR: begin
                imm        = {{55{instruction_ID[20]}}, instruction_ID[20:12]};
                alu        = 4'b0010;
                c_alusrc   = 1'b1;
                c_memtoreg = 1'b1;
                c_regwrite = 1'b1;
                c_memread  = 1'b1;
            end
            OP_STUR: begin
                imm        = {{55{instruction_ID[20]}}, instruction_ID[20:12]};
                alu        = 4'b0010;
                c_alusrc   = 1'b1;
                c_memwrite = 1'b1;
            end
            OP_ADD: begin
                alu        = 4'b0010;
                c_regwrite = 1'b1;
            end
            OP_SUB: begin
                alu        = 4'b0110;
                c_regwrite = 1'b1;
            end
            OP_AND: begin
                alu        = 4'b0000;
                c_regwrite = 1'b1;
            end
            OP_ORR: begin
                alu        = 4'b0001;
                c_regwrite = 1'b1;
            end
            OP_CBZ: begin
                imm      = {{45{instruction_ID[23]}}, instruction_ID[23:5]};
                alu      = 4'b0111;
                c_branch = 1'b1;
            end
            OP_B: begin
                imm      = {{38{instruction_ID[25]}}, instruction_ID[25:0]};
                c_uncond = 1'b1;
            end
            OP_MOVZ: begin
                // hw selects which 16-bit lane the immediate lands in.
                imm        = {48'd0, instruction_ID[20:5]} << {instruction_ID[22:21], 4'b0000};
                alu        = 4'b0111;
                c_alusrc   = 1'b1;
                c_regwrite = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_EX           <= RESET_PC;
            busA_EX         <= '0;
            busB_EX         <= '0;
            extimm_EX       <= '0;
            rd_EX           <= '0;
            alu_ctrl_EX     <= '0;
            alusrc_EX       <= 1'b0;
            memtoreg_EX     <= 1'b0;
            regwrite_EX     <= 1'b0;
            memread_EX      <= 1'b0;
            memwrite_EX     <= 1'b0;
            branch_EX       <= 1'b0;
            uncondbranch_EX <= 1'b0;
            invalid_EX      <= 1'b0;
        end else if (flush) begin
            pc_EX           <= '0;
            busA_EX         <= '0;
            busB_EX         <= '0;
            extimm_EX       <= '0;
            rd_EX           <= '0;
            alu_ctrl_EX     <= '0;
            alusrc_EX       <= 1'b0;
            memtoreg_EX     <= 1'b0;
            regwrite_EX     <= 1'b0;
            memread_EX      <= 1'b0;
            memwrite_EX     <= 1'b0;
            branch_EX       <= 1'b0;
            uncondbranch_EX <= 1'b0;
            invalid_EX      <= 1'b0;
        end else begin
            pc_EX           <= pc_ID;
            busA_EX         <= read_a;
            busB_EX         <= read_b;
            extimm_EX       <= imm;
            rd_EX           <= instruction_ID[4:0];
            alu_ctrl_EX     <= alu;
            alusrc_EX       <= c_alusrc;
            memtoreg_EX     <= c_memtoreg;
            regwrite_EX     <= c_regwrite;
            memread_EX      <= c_memread;
            memwrite_EX     <= c_memwrite;
            branch_EX       <= c_branch;
            uncondbranch_EX <= c_uncond;
            invalid_EX      <= (op == OP_INV);
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - self-checking bench for instruction_decode
module tb_instruction_decode;

    localparam logic [63:0] RPC = 64'h0000_0000_0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction_ID = '0;
    logic [63:0] pc_ID = '0;
    logic        flush = 1'b0;
    logic        wb_regwrite = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [63:0] wb_data = '0;
    logic [63:0] pc_EX, busA_EX, busB_EX, extimm_EX;
    logic [4:0]  rd_EX;
    logic [3:0]  alu_ctrl_EX;
    logic        alusrc_EX, memtoreg_EX, regwrite_EX, memread_EX, memwrite_EX;
    logic        branch_EX, uncondbranch_EX, invalid_EX;

    instruction_decode #(.ZERO_REG(31), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .instruction_ID(instruction_ID), .pc_ID(pc_ID),
        .flush(flush), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .pc_EX(pc_EX), .busA_EX(busA_EX), .busB_EX(busB_EX), .extimm_EX(extimm_EX),
        .rd_EX(rd_EX), .alu_ctrl_EX(alu_ctrl_EX), .alusrc_EX(alusrc_EX),
        .memtoreg_EX(memtoreg_EX), .regwrite_EX(regwrite_EX), .memread_EX(memread_EX),
        .memwrite_EX(memwrite_EX), .branch_EX(branch_EX), .uncondbranch_EX(uncondbranch_EX),
        .invalid_EX(invalid_EX)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] mregs [32];
    logic [63:0] e_pc, e_a, e_b, e_imm;
    logic [4:0]  e_rd;
    logic [3:0]  e_alu;
    logic        e_alusrc, e_memtoreg, e_regwrite, e_memread, e_memwrite, e_branch, e_uncond, e_inv;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mread(input logic [4:0] idx, input logic wbw,
                                          input logic [4:0] wrd, input logic [63:0] wd);
        if (idx == 5'd31) return 64'd0;
        if (wbw && wrd == idx) return wd;
        return mregs[idx];
    endfunction

    // Reference: classify by opcode field, then fill in the expected ID/EX entry.
    task automatic model(input logic [31:0] ins, input logic [63:0] pc, input logic fl,
                         input logic wbw, input logic [4:0] wrd, input logic [63:0] wd);
        longint sx;
        string  kind;
        if      (ins[31:21] == 11'b11111000010) kind = "LDUR";
        else if (ins[31:21] == 11'b11111000000) kind = "STUR";
        else if (ins[31:21] == 11'b10001011000) kind = "ADD";
        else if (ins[31:21] == 11'b11001011000) kind = "SUB";
        else if (ins[31:21] == 11'b10001010000) kind = "AND";
        else if (ins[31:21] == 11'b10101010000) kind = "ORR";
        else if (ins[31:24] == 8'b10110100)     kind = "CBZ";
        else if (ins[31:26] == 6'b000101)       kind = "B";
        else if (ins[31:23] == 9'b110100101)    kind = "MOVZ";
        else                                    kind = "BAD";
        e_pc = pc; e_rd = ins[4:0]; e_imm = 0; e_alu = 0;
        e_alusrc = 0; e_memtoreg = 0; e_regwrite = 0; e_memread = 0;
        e_memwrite = 0; e_branch = 0; e_uncond = 0; e_inv = 0;
        e_a = mread(ins[9:5], wbw, wrd, wd);
        e_b = mread((kind == "STUR" || kind == "CBZ") ? ins[4:0] : ins[20:16], wbw, wrd, wd);
        case (kind)
            "LDUR": begin sx = $signed(ins[20:12]); e_imm = sx; e_alu = 2;
                          e_alusrc = 1; e_memtoreg = 1; e_regwrite = 1; e_memread = 1; end
            "STUR": begin sx = $signed(ins[20:12]); e_imm = sx; e_alu = 2;
                          e_alusrc = 1; e_memwrite = 1; end
            "ADD":  begin e_alu = 2; e_regwrite = 1; end
            "SUB":  begin e_alu = 6; e_regwrite = 1; end
            "AND":  begin e_alu = 0; e_regwrite = 1; end
            "ORR":  begin e_alu = 1; e_regwrite = 1; end
            "CBZ":  begin sx = $signed(ins[23:5]); e_imm = sx; e_alu = 7; e_branch = 1; end
            "B":    begin sx = $signed(ins[25:0]); e_imm = sx; e_uncond = 1; end
            "MOVZ": begin e_imm = 64'(ins[20:5]) * (64'd1 << (16 * int'(ins[22:21])));
                          e_alu = 7; e_alusrc = 1; e_regwrite = 1; end
            default: e_inv = 1;
        endcase
        if (fl) begin
            e_pc = 0; e_a = 0; e_b = 0; e_imm = 0; e_rd = 0; e_alu = 0;
            e_alusrc = 0; e_memtoreg = 0; e_regwrite = 0; e_memread = 0;
            e_memwrite = 0; e_branch = 0; e_uncond = 0; e_inv = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, pc_EX, e_pc);
        chk({tag, ".busA"}, busA_EX, e_a);
        chk({tag, ".busB"}, busB_EX, e_b);
        chk({tag, ".extimm"}, extimm_EX, e_imm);
        chk({tag, ".rd"}, 64'(rd_EX), 64'(e_rd));
        chk({tag, ".alu"}, 64'(alu_ctrl_EX), 64'(e_alu));
        chk({tag, ".ctrl"},
            64'({alusrc_EX, memtoreg_EX, regwrite_EX, memread_EX, memwrite_EX, branch_EX, uncondbranch_EX, invalid_EX}),
            64'({e_alusrc, e_memtoreg, e_regwrite, e_memread, e_memwrite, e_branch, e_uncond, e_inv}));
    endtask

    task automatic check_reset_state(input string tag);
        e_pc = RPC; e_a = 0; e_b = 0; e_imm = 0; e_rd = 0; e_alu = 0;
        e_alusrc = 0; e_memtoreg = 0; e_regwrite = 0; e_memread = 0;
        e_memwrite = 0; e_branch = 0; e_uncond = 0; e_inv = 0;
        check_all(tag);
    endtask

    task automatic cycle(input logic [31:0] ins, input logic [63:0] pc, input logic fl,
                         input logic wbw, input logic [4:0] wrd, input logic [63:0] wd,
                         input string tag);
        @(negedge clk);
        instruction_ID = ins; pc_ID = pc; flush = fl;
        wb_regwrite = wbw; wb_rd = wrd; wb_data = wd;
        model(ins, pc, fl, wbw, wrd, wd);
        @(posedge clk);
        #1;
        if (wbw && wrd != 5'd31) mregs[wrd] = wd;
        check_all(tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r[31:21] = 11'b11111000010;
            1: r[31:21] = 11'b11111000000;
            2: r[31:21] = 11'b10001011000;
            3: r[31:21] = 11'b11001011000;
            4: r[31:21] = 11'b10001010000;
            5: r[31:21] = 11'b10101010000;
            6: r[31:24] = 8'b10110100;
            7: r[31:26] = 6'b000101;
            8: r[31:23] = 9'b110100101;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset0");
        @(negedge clk);
        reset = 1'b0;

        // Preload X1=5, X2=7, X9 random while decoding 0x0 (invalid)
        cycle(32'h0, 64'h1000, 0, 1, 5'd1, 64'd5, "pre1");
        chk("zero_invalid", 64'(invalid_EX), 64'd1);
        cycle(32'h0, 64'h1004, 0, 1, 5'd2, 64'd7, "pre2");
        cycle(32'h0, 64'h1008, 0, 1, 5'd9, {$urandom, $urandom}, "pre9");

        // ADD X3,X1,X2
        cycle(32'h8B020023, 64'h2000, 0, 0, 5'd0, 64'd0, "add");
        chk("add_busA", busA_EX, 64'd5);
        chk("add_busB", busB_EX, 64'd7);
        chk("add_rd", 64'(rd_EX), 64'd3);
        chk("add_alu", 64'(alu_ctrl_EX), 64'b0010);
        chk("add_regwrite", 64'(regwrite_EX), 64'd1);

        // LDUR X5,[X1,#-8]
        cycle(32'hF85F8025, 64'h2004, 0, 0, 5'd0, 64'd0, "ldur");
        chk("ldur_imm", extimm_EX, 64'hFFFFFFFFFFFFFFF8);
        chk("ldur_memread", 64'(memread_EX), 64'd1);

        // CBZ X9,-1
        cycle(32'hB4FFFFE9, 64'h2008, 0, 0, 5'd0, 64'd0, "cbz");
        chk("cbz_busB", busB_EX, mregs[9]);
        chk("cbz_imm", extimm_EX, 64'hFFFFFFFFFFFFFFFF);
        chk("cbz_branch", 64'(branch_EX), 64'd1);

        // MOVZ X4,#0x1234,LSL16
        cycle(32'hD2A24684, 64'h200C, 0, 0, 5'd0, 64'd0, "movz");
        chk("movz_imm", extimm_EX, 64'h12340000);
        chk("movz_alu", 64'(alu_ctrl_EX), 64'b0111);

        // Same-cycle write-back bypass, and X31 ignores writes
        cycle(32'h8B020023, 64'h2010, 0, 1, 5'd1, 64'hAA, "bypass");
        chk("bypass_busA", busA_EX, 64'hAA);
        cycle(32'h8B0203E3, 64'h2014, 0, 1, 5'd31, 64'h55, "x31_write");
        chk("x31_busA", busA_EX, 64'd0);
        cycle(32'h8B0203E3, 64'h2018, 0, 0, 5'd0, 64'd0, "x31_read");
        chk("x31_busA2", busA_EX, 64'd0);

        // Flush with a valid ADD present; the register write still happens
        cycle(32'h8B020023, 64'h201C, 1, 1, 5'd2, 64'h77, "flush");
        chk("flush_regwrite", 64'(regwrite_EX), 64'd0);
        cycle(32'h8B020023, 64'h2020, 0, 0, 5'd0, 64'd0, "after_flush");
        chk("flush_wb_kept", busB_EX, 64'h77);

        // Random stimulus
        for (int n = 0; n < 300; n++) begin
            cycle(rand_instr(), {$urandom, $urandom}, ($urandom_range(0, 7) == 0),
                  1'($urandom), 5'($urandom), {$urandom, $urandom}, "rand");
        end

        // Asynchronous reset mid-cycle, with a write-back attempt that must be ignored
        @(negedge clk);
        instruction_ID = 32'h8B020023; flush = 1'b0;
        wb_regwrite = 1'b1; wb_rd = 5'd1; wb_data = 64'h99;
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        @(posedge clk);
        #1;
        check_reset_state("reset_hold");
        @(negedge clk);
        reset = 1'b0;
        wb_regwrite = 1'b0;

        cycle(32'h0, 64'h3000, 0, 0, 5'd0, 64'd0, "post_zero");
        chk("post_zero_invalid", 64'(invalid_EX), 64'd1);
        chk("post_zero_regwrite", 64'(regwrite_EX), 64'd0);
        cycle(32'h8B020023, 64'h3004, 0, 0, 5'd0, 64'd0, "post_add");
        chk("post_x1_cleared", busA_EX, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have parameter ZERO_REG, default 31, meaning the register index that always reads 0 and ignores writes.
REQ-002 SHALL have parameter RESET_PC, default 64'h0, meaning the pc_EX value after reset.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port instruction_ID  input  32  instruction from the fetch stage pipeline register.
REQ-006 SHALL have port pc_ID  input  64  PC of instruction_ID.
REQ-007 SHALL have port flush  input  1  turns the next ID/EX entry into a bubble (taken branch).
REQ-008 SHALL have port wb_regwrite  input  1  write-back enable.
REQ-009 SHALL have port wb_rd  input  5  write-back destination register.
REQ-010 SHALL have port wb_data  input  64  write-back data.
REQ-011 SHALL have port pc_EX  output  64  registered PC.
REQ-012 SHALL have ports busA_EX and busB_EX  output  64 each  registered operand reads.
REQ-013 SHALL have port extimm_EX  output  64  registered extended immediate.
REQ-014 SHALL have port rd_EX  output  5  registered destination, instruction[4:0].
REQ-015 SHALL have port alu_ctrl_EX  output  4  registered ALU operation.
REQ-016 SHALL have ports alusrc_EX, memtoreg_EX, regwrite_EX, memread_EX, memwrite_EX, branch_EX, uncondbranch_EX, invalid_EX  output  1 each  registered control bits.

Function
REQ-017 SHALL hold a 32x64 register file; write at posedge clk when wb_regwrite=1 and wb_rd!=ZERO_REG.
REQ-018 SHALL return 0 for any read of ZERO_REG.
REQ-019 SHALL forward wb_data to a read port in the same cycle when wb_regwrite=1, wb_rd matches that port's address, and the address is not ZERO_REG.
REQ-020 SHALL read port A at Rn=instr[9:5].
REQ-021 SHALL read port B at instr[4:0] for STUR and CBZ, and at Rm=instr[20:16] otherwise.
REQ-022 SHALL decode these opcodes: LDUR [31:21]=11111000010, STUR 11111000000, ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, CBZ [31:24]=10110100, B [31:26]=000101, MOVZ [31:23]=110100101.
REQ-023 SHALL encode alu_ctrl as AND 0000, ORR 0001, ADD/LDUR/STUR 0010, SUB 0110, CBZ/MOVZ 0111 (pass B); B SHALL use 0000.
REQ-024 SHALL set the control bits per instruction, with all unlisted bits 0: LDUR alusrc, memtoreg, regwrite, memread; STUR alusrc, memwrite; R-type regwrite; CBZ branch; B uncondbranch; MOVZ alusrc, regwrite.
REQ-025 SHALL form extimm by sign-extending imm9[20:12] for D-type, imm19[23:5] for CB, and imm26[25:0] for B, with no shift; MOVZ SHALL use zero-extended imm16[20:5] << (16*hw[22:21]); R-type SHALL use 0.
REQ-026 SHALL treat an unrecognised opcode as a bubble (all control bits 0, alu_ctrl 0) with invalid_EX=1.
REQ-027 SHALL register all ID/EX outputs at posedge clk, giving 1-cycle latency from instruction_ID/pc_ID to the *_EX outputs.
REQ-028 SHALL, when flush=1, clear all control bits, invalid_EX and alu_ctrl in the next entry; the data fields are don't-care and SHALL be driven 0.
REQ-029 SHALL give flush priority over decode, and SHALL still perform a same-cycle register file write when flush=1.
REQ-030 SHALL decode instruction_ID=32'h0 (fetch reset output) as invalid, so it becomes a bubble.

Reset
REQ-031 SHALL, while reset=1, immediately clear all ID/EX outputs to 0 (pc_EX=RESET_PC) and all 32 registers to 0, independent of clk.
REQ-032 SHALL ignore write-back while reset=1; deassertion mid-stream SHALL resume normal decode at the first following posedge.

Verification
REQ-033 Preload X1=5 and X2=7, then apply 0x8B020023 (ADD X3,X1,X2) -> next cycle busA_EX=5, busB_EX=7, rd_EX=3, alu_ctrl_EX=0010, regwrite_EX=1, alusrc_EX=0.
REQ-034 Apply 0xF85F8025 (LDUR X5,[X1,#-8]) -> extimm_EX=64'hFFFFFFFFFFFFFFF8 with alusrc, memread, memtoreg and regwrite set to 1; 0xB4FFFFE9 (CBZ X9,-1) -> busB_EX=X9, extimm_EX all ones, branch_EX=1.
REQ-035 Apply 0xD2A24684 (MOVZ X4,#0x1234,LSL16) -> extimm_EX=64'h12340000, alu_ctrl_EX=0111.
REQ-036 Drive wb_regwrite=1, wb_rd=1, wb_data=0xAA while decoding ADD X3,X1,X2 -> busA_EX=0xAA (bypass); with wb_rd=31 -> X31 still reads 0.
REQ-037 Assert flush with a valid ADD present, then reset asynchronously mid-cycle, then apply 0x0 -> flush gives all controls 0 next cycle; reset clears outputs before any edge; 0x0 gives invalid_EX=1 with regwrite_EX=0.
